vga_fb_arbiter: RTL

- Shares one single-port framebuffer RAM between two requesters:
  - display line prefetch, triggered by the VGA timing counter's per-line strobes, which writes one line of words into the scan-out line buffer;
  - a host write/read port.
- Display fetch has priority. The host is served in every cycle the fetch engine is idle.
- Sits between the VGA timing counter, the framebuffer RAM, the line buffer and the host bus.

---
 rtl/vga_fb_pkg.sv | 20 ++
 rtl/vga_fetch_addr_gen.sv | 66 ++++++
 rtl/vga_fb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_fb_pkg
// Brief   : Default geometry and arbiter state encoding for vga_fb_arbiter.
// Revision: 1.0
// ============================================================================
package vga_fb_pkg;

    localparam int c_ADDR_W         = 16;
    localparam int c_DATA_W         = 16;
    localparam int c_WORDS_PER_LINE = 40;
    localparam int c_LINES          = 600;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_FETCH = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fetch_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_fetch_addr_gen
// Brief   : Line index / word counter for display prefetch and frame/line strobes.
// Revision: 1.0
// ============================================================================
module vga_fetch_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W,
    parameter int WORDS_PER_LINE = c_WORDS_PER_LINE,
    parameter int LINES          = c_LINES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                frame_start,
    input  logic                                line_start,
    input  logic                                in_fetch,
    input  logic                                issue,
    output logic                                start_ok,
    output logic                                last_word,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   word,
    output logic [ADDR_W-1:0]                   addr
);

    localparam int c_IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int c_LINE_W = $clog2(LINES + 1);

    logic [c_LINE_W-1:0] r_line;
    logic [c_IDX_W-1:0]  r_word;
    logic [c_LINE_W-1:0] w_line_inc;
    logic [c_LINE_W-1:0] w_target;

    assign w_line_inc = (r_line == c_LINE_W'(LINES)) ? r_line : r_line + 1'b1;

    // A line_start during a fetch abandons the current line and targets the next one.
    assign w_target  = frame_start ? '0 : (in_fetch ? w_line_inc : r_line);
    assign start_ok  = line_start && (w_target < c_LINE_W'(LINES));
    assign last_word = (r_word == c_IDX_W'(WORDS_PER_LINE - 1));
    assign word      = r_word;
    assign addr      = ADDR_W'(r_line) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(r_word);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
            r_word <= '0;
        end else if (frame_start) begin
            r_line <= '0;
            r_word <= '0;
        end else if (line_start) begin
            if (in_fetch) begin
                r_line <= w_line_inc;
            end
            r_word <= '0;
        end else if (issue) begin
            if (last_word) begin
                r_line <= w_line_inc;
                r_word <= '0;
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_fb_arbiter
// Brief   : Framebuffer RAM arbiter, display prefetch over host; optional
//           forced host slot via VGA_FB_HOST_SLOT_EN.
// Revision: 1.0
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W         = c_ADDR_W,
    parameter int DATA_W         = c_DATA_W,
    parameter int WORDS_PER_LINE = c_WORDS_PER_LINE,
    parameter int LINES          = c_LINES
`ifdef VGA_FB_HOST_SLOT_EN
    ,
    parameter int MAX_FETCH_RUN  = 8
`endif
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                frame_start,
    input  logic                                line_start,
    input  logic                                host_req,
    input  logic                                host_we,
    input  logic [ADDR_W-1:0]                   host_addr,
    input  logic [DATA_W-1:0]                   host_wdata,
    output logic                                host_gnt,
    output logic [DATA_W-1:0]                   host_rdata,
    output logic                                host_rvalid,
    output logic                                mem_en,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [DATA_W-1:0]                   mem_wdata,
    input  logic [DATA_W-1:0]                   mem_rdata,
    output logic                                lb_wvalid,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   lb_widx,
    output logic [DATA_W-1:0]                   lb_wdata,
    output logic                                fetch_busy,
    output logic                                fetch_overrun
);

    arb_state_t                          r_state;
    logic                                w_in_fetch;
    logic                                w_slot;
    logic                                w_issue;
    logic                                w_start_ok;
    logic                                w_last_word;
    logic [$clog2(WORDS_PER_LINE)-1:0]   w_word;
    logic [ADDR_W-1:0]                   w_fetch_addr;

    assign w_in_fetch = (r_state == ARB_FETCH);

`ifdef VGA_FB_HOST_SLOT_EN
    localparam int c_RUN_W = $clog2(MAX_FETCH_RUN + 1);
    logic [c_RUN_W-1:0] r_run;

    // After MAX_FETCH_RUN back-to-back fetch cycles with the host waiting, steal one cycle.
    assign w_slot = w_in_fetch && host_req && (r_run == c_RUN_W'(MAX_FETCH_RUN));

    always_ff @(posedge clk) begin
        if (reset || !w_in_fetch || !host_req || w_slot) begin
            r_run <= '0;
        end else begin
            r_run <= r_run + 1'b1;
        end
    end
`else
    assign w_slot = 1'b0;
`endif

    assign w_issue   = !reset && w_in_fetch && !w_slot;
    assign host_gnt  = !reset && host_req && (!w_in_fetch || w_slot);
    assign mem_en    = w_issue || host_gnt;
    assign mem_we    = host_gnt && host_we;
    assign mem_addr  = w_issue ? w_fetch_addr : (host_gnt ? host_addr : '0);
    assign mem_wdata = host_gnt ? host_wdata : '0;

    assign lb_wdata   = lb_wvalid ? mem_rdata : '0;
    assign host_rdata = host_rvalid ? mem_rdata : '0;

    vga_fetch_addr_gen #(
        .ADDR_W         (ADDR_W),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES          (LINES)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .line_start  (line_start),
        .in_fetch    (w_in_fetch),
        .issue       (w_issue),
        .start_ok    (w_start_ok),
        .last_word   (w_last_word),
        .word        (w_word),
        .addr        (w_fetch_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            fetch_busy    <= 1'b0;
            fetch_overrun <= 1'b0;
            lb_wvalid     <= 1'b0;
            lb_widx       <= '0;
            host_rvalid   <= 1'b0;
        end else begin
            if (frame_start || line_start) begin
                r_state    <= w_start_ok ? ARB_FETCH : ARB_IDLE;
                fetch_busy <= w_start_ok;
            end else if (w_issue && w_last_word) begin
                r_state    <= ARB_IDLE;
                fetch_busy <= 1'b0;
            end
            if (line_start && w_in_fetch && !frame_start) begin
                fetch_overrun <= 1'b1;
            end
            // Tag the read issued this cycle so its data lands next cycle.
            lb_wvalid   <= w_issue;
            lb_widx     <= w_word;
            host_rvalid <= host_gnt && !host_we;
        end
    end

endmodule
`default_nettype wire
